// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: in-order instruction prefetcher with credit-limited reads,
// a DEPTH-entry {pc, inst} FIFO and flush/drain handling for redirects.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);
    localparam int CW = $clog2(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW:0]   count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [CW+1:0] used, in_flight;
    logic          issue, push, pop;

    always_comb begin
        used      = {1'b0, count_q} + {1'b0, outst_q};
        // reads still owed by memory once this cycle's response (if any) is consumed
        in_flight = {1'b0, drop_q} + {1'b0, outst_q}
                  - (CW+2)'(mem_rvalid && (drop_q != '0 || outst_q != '0));
        mem_req   = rst && state_q == FETCH && used < (CW+2)'(DEPTH) && !redirect;
        issue     = mem_req && mem_rdy;
        push      = state_q == FETCH && mem_rvalid && !redirect;
        pop       = count_q != '0 && !stall && !redirect;
        state_d    = state_q;
        fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
        count_d    = count_q + (CW+1)'(push) - (CW+1)'(pop);
        outst_d    = outst_q + (CW+1)'(issue) - (CW+1)'(push);
        drop_d     = drop_q;
        rd_ptr_d   = pop ? rd_ptr_q + CW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + CW'(1) : wr_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'd3;
            resp_pc_d  = redirect_pc & ~32'd3;
            count_d    = '0;
            outst_d    = '0;
            drop_d     = in_flight[CW:0];
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            state_d    = in_flight != '0 ? DRAIN : FETCH;
        end else if (state_q == DRAIN && mem_rvalid) begin
            drop_d  = drop_q - (CW+1)'(1);
            state_d = drop_q == (CW+1)'(1) ? FETCH : DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= resp_pc_q;
                inst_mem_q[wr_ptr_q] <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) assert (!(push && !pop && count_q == (CW+1)'(DEPTH)))
            else $fatal(1, "fetch_prefetch_queue: push into full queue");
    end

    assign mem_addr  = fetch_pc_q & ~32'd3;
    assign out_valid = count_q != '0;
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_pc4   = out_pc + 32'd4;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed and random checks of the prefetch queue
// against a queue-based reference of fetched entries and in-flight reads.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 0, rst = 0, stall = 0, redirect = 0, mem_rdy = 1;
    logic        mem_rvalid = 0, mem_req, out_valid;
    logic [31:0] redirect_pc = 0, mem_rdata = 0, mem_addr, out_inst, out_pc, out_pc4;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_pc4(out_pc4)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    typedef struct {logic [31:0] a; bit stale; int due;} fl_t;

    ent_t        fifo[$];
    fl_t         infl[$];
    logic [31:0] m_fetch_pc;
    int          cyc = 0, lat = 1, dut_issued = 0;
    int          checks = 0, errors = 0;

    function automatic logic [31:0] memv(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit any_stale();
        foreach (infl[i]) if (infl[i].stale) return 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        if (infl.size() != 0 && infl[0].due <= cyc) begin
            mem_rvalid = 1;
            mem_rdata  = memv(infl[0].a);
        end else begin
            mem_rvalid = 0;
            mem_rdata  = $urandom;
        end
    endtask

    // One clock cycle: compare against the model, advance it, step to next negedge.
    task automatic tick();
        bit   exp_req;
        fl_t  f;
        int   due;
        #1;
        exp_req = rst && !any_stale() && (fifo.size() + infl.size() < DEPTH) && !redirect;
        chk("mem_req", mem_req, exp_req);
        if (exp_req) chk("mem_addr", mem_addr, m_fetch_pc);
        chk("out_valid", out_valid, fifo.size() != 0);
        if (fifo.size() != 0) begin
            chk("out_pc", out_pc, fifo[0].pc);
            chk("out_inst", out_inst, fifo[0].inst);
            chk("out_pc4", out_pc4, fifo[0].pc + 32'd4);
        end
        if (mem_req && mem_rdy) dut_issued++;
        if (fifo.size() != 0 && !stall && !redirect) void'(fifo.pop_front());
        if (mem_rvalid) begin
            f = infl.pop_front();
            if (!f.stale && !redirect) fifo.push_back('{f.a, memv(f.a)});
        end
        if (redirect) begin
            fifo.delete();
            foreach (infl[i]) infl[i].stale = 1;
            m_fetch_pc = redirect_pc & ~32'd3;
        end
        if (exp_req && mem_rdy) begin
            due = cyc + lat;
            if (infl.size() != 0 && infl[$].due >= due) due = infl[$].due + 1;
            infl.push_back('{m_fetch_pc, 1'b0, due});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mem_drive();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_pc4", out_pc4, 32'd4);
    endtask

    task automatic do_reset();
        rst = 0; stall = 0; redirect = 0; mem_rdy = 1;
        #1;
        chk_reset_outputs();
        fifo.delete();
        infl.delete();
        m_fetch_pc = 32'h0;
        @(negedge clk);
        rst = 1;
        mem_drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1-cycle memory streaming from reset
        lat = 1;
        do_reset();
        tick();
        #1 chk("first_valid_early", out_valid, 0);
        tick();
        #1 chk("first_valid", out_valid, 1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_pc4", out_pc4, 32'h4);
        repeat (10) tick();

        // stall from reset: exactly DEPTH requests, head held
        do_reset();
        stall = 1;
        dut_issued = 0;
        repeat (10) tick();
        chk("stall_issued", dut_issued, 4);
        #1 chk("stall_head_pc", out_pc, 32'h0);
        stall = 0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("release_pc", out_pc, 32'(4 * k));
            tick();
        end
        repeat (4) tick();

        // 3-cycle memory, redirect with two reads in flight
        lat = 3;
        do_reset();
        repeat (2) tick();
        redirect = 1; redirect_pc = 32'h40;
        tick();
        redirect = 0;
        for (int i = 0; i < 20; i++) begin
            #1 if (out_valid) break;
            tick();
        end
        #1 chk("redir_valid", out_valid, 1);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_inst", out_inst, memv(32'h40));
        repeat (4) tick();

        // redirect coinciding with a response while stalled
        lat = 1;
        do_reset();
        repeat (3) tick();
        for (int i = 0; i < 10 && !mem_rvalid; i++) tick();
        stall = 1; redirect = 1; redirect_pc = 32'h123;
        tick();
        stall = 0; redirect = 0;
        #1 chk("flush_valid", out_valid, 0);
        for (int i = 0; i < 10; i++) begin
            #1 if (mem_req) break;
            tick();
        end
        #1 chk("post_redir_req", mem_req, 1);
        chk("post_redir_addr", mem_addr, 32'h120);
        repeat (4) tick();

        // memory back-pressure holds the request
        do_reset();
        repeat (4) tick();
        mem_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_req", mem_req, 1);
            chk("hold_addr", mem_addr, 32'h10);
            tick();
        end
        mem_rdy = 1;
        tick();
        #1 chk("after_accept_addr", mem_addr, 32'h14);
        repeat (3) tick();

        // asynchronous reset with count=3, outstanding=1
        do_reset();
        stall = 1;
        repeat (4) tick();
        #1 chk("pre_reset_valid", out_valid, 1);
        #1 rst = 0;
        #1 chk_reset_outputs();
        fifo.delete();
        infl.delete();
        m_fetch_pc = 32'h0;
        stall = 0;
        @(negedge clk);
        rst = 1;
        mem_drive();
        #1 chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, 32'h0);
        repeat (6) tick();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            stall       = $urandom_range(0, 99) < 30;
            redirect    = $urandom_range(0, 99) < 5;
            redirect_pc = $urandom;
            mem_rdy     = $urandom_range(0, 99) < 70;
            lat         = $urandom_range(1, 4);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
